// File: rtl/home_pkg.sv
// Shared constants and types for the home security front end: keypad codes,
// pin words driven toward the mode FSM, and the PIN-entry state encoding.
package home_pkg;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;

    localparam logic [3:0] PIN_DISARM = 4'b0000;
    localparam logic [3:0] PIN_IDLE   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKOUT = 2'd3
    } pin_state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter: start loads load_val, done pulses for one cycle once
// the count has run down to zero; clear abandons the count.
module cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic             active_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            count_q  <= load_val;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (count_q == '0) begin
                active_q <= 1'b0;
            end else begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign done = active_q && (count_q == '0);

endmodule

// File: rtl/pin_entry_controller.sv
// Keypad PIN entry: buffers BCD digits, checks them against a stored code on
// enter, pulses the disarm word on a match and locks out after repeated misses.
module pin_entry_controller
    import home_pkg::*;
#(
    parameter int unsigned          DIGITS         = 4,
    parameter int unsigned          MAX_FAILS      = 3,
    parameter int unsigned          LOCKOUT_CYCLES = 1000,
    parameter int unsigned          TIMEOUT_CYCLES = 500,
    parameter logic [4*DIGITS-1:0]  DEFAULT_CODE   = 16'h1234,
    localparam int unsigned         COUNT_W        = $clog2(DIGITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic                code_wr,
    input  logic [4*DIGITS-1:0] code_in,
    output logic [3:0]          pin_out,
    output logic                pin_ok,
    output logic                pin_fail,
    output logic                locked,
    output logic [COUNT_W-1:0]  digit_count
);

    localparam int unsigned BUF_W  = 4 * DIGITS;
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DIGITS);
    localparam logic [FAIL_W-1:0]  LAST_FAIL  = FAIL_W'(MAX_FAILS - 1);
    localparam logic [TMO_W-1:0]   TMO_LOAD   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LOCK_W-1:0]  LOCK_LOAD  = LOCK_W'(LOCKOUT_CYCLES - 1);

    pin_state_e         state_q, state_d;
    logic [BUF_W-1:0]   buffer_q, buffer_d;
    logic [BUF_W-1:0]   stored_q, stored_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [FAIL_W-1:0]  fails_q, fails_d;
    logic               ok_d, fail_d;
    logic               pin_ok_q, pin_fail_q;
    logic [3:0]         pin_out_q;
    logic               tmo_start, tmo_clear, tmo_done;
    logic               lock_start, lock_done;

    always_comb begin
        state_d    = state_q;
        buffer_d   = buffer_q;
        stored_d   = stored_q;
        count_d    = count_q;
        fails_d    = fails_q;
        ok_d       = 1'b0;
        fail_d     = 1'b0;
        tmo_start  = 1'b0;
        tmo_clear  = 1'b0;
        lock_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A code write takes the cycle; any key arriving with it is dropped.
                if (code_wr) begin
                    stored_d = code_in;
                end else if (key_valid && is_digit(key_code)) begin
                    buffer_d  = BUF_W'({buffer_q, key_code});
                    count_d   = COUNT_W'(1);
                    state_d   = ST_ENTRY;
                    tmo_start = 1'b1;
                end
            end
            ST_ENTRY: begin
                if (key_valid) begin
                    if (key_code == KEY_CLEAR) begin
                        buffer_d  = '0;
                        count_d   = '0;
                        state_d   = ST_IDLE;
                        tmo_clear = 1'b1;
                    end else if (key_code == KEY_ENTER) begin
                        state_d   = ST_CHECK;
                        tmo_clear = 1'b1;
                    end else begin
                        tmo_start = 1'b1;
                        if (is_digit(key_code) && count_q < FULL_COUNT) begin
                            buffer_d = BUF_W'({buffer_q, key_code});
                            count_d  = count_q + 1'b1;
                        end
                    end
                end else if (tmo_done) begin
                    buffer_d = '0;
                    count_d  = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_CHECK: begin
                buffer_d = '0;
                count_d  = '0;
                if (count_q == FULL_COUNT && buffer_q == stored_q) begin
                    ok_d    = 1'b1;
                    fails_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    fail_d = 1'b1;
                    if (fails_q == LAST_FAIL) begin
                        fails_d    = '0;
                        state_d    = ST_LOCKOUT;
                        lock_start = 1'b1;
                    end else begin
                        fails_d = fails_q + 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (lock_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            buffer_q   <= '0;
            stored_q   <= DEFAULT_CODE;
            count_q    <= '0;
            fails_q    <= '0;
            pin_ok_q   <= 1'b0;
            pin_fail_q <= 1'b0;
            pin_out_q  <= PIN_IDLE;
        end else begin
            state_q    <= state_d;
            buffer_q   <= buffer_d;
            stored_q   <= stored_d;
            count_q    <= count_d;
            fails_q    <= fails_d;
            pin_ok_q   <= ok_d;
            pin_fail_q <= fail_d;
            pin_out_q  <= ok_d ? PIN_DISARM : PIN_IDLE;
        end
    end

    cycle_timer #(
        .WIDTH (TMO_W)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .start    (tmo_start),
        .clear    (tmo_clear),
        .load_val (TMO_LOAD),
        .done     (tmo_done)
    );

    cycle_timer #(
        .WIDTH (LOCK_W)
    ) u_lockout (
        .clk      (clk),
        .rst      (rst),
        .start    (lock_start),
        .clear    (1'b0),
        .load_val (LOCK_LOAD),
        .done     (lock_done)
    );

    assign pin_out     = pin_out_q;
    assign pin_ok      = pin_ok_q;
    assign pin_fail    = pin_fail_q;
    assign locked      = (state_q == ST_LOCKOUT);
    assign digit_count = count_q;

endmodule
